// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the register-file port arbiter.
// Optional feature macro: REGFILE_ARB_LOCK_EN (adds grant locking).
package regfile_arb_pkg;

  localparam int unsigned NUM_REQ      = 2;
  localparam int unsigned DATA_W_DEF   = 8;
  localparam int unsigned ADDR_W_DEF   = 3;
  localparam int unsigned LOCK_MAX_DEF = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } arb_state_t;

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
  typedef logic [DATA_W_DEF-1:0] reg_data_t;

  // Index of the opposite requester in a two-way arbiter.
  function automatic logic other_req(input logic idx);
    return ~idx;
  endfunction

endpackage

// File: rtl/regfile_arbiter_rr_picker.sv
// Combinational two-way round-robin pick with an optional lock override.
module rr_picker
  import regfile_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] eligible,
  input  logic               lastGrant,
  input  logic               lockValid,
  input  logic               lockOwner,
  output logic               winner,
  output logic               valid
);

  // A live lock wins outright if its owner is asking; otherwise alternate.
  always_comb begin
    valid  = |eligible;
    winner = 1'b0;
    if (lockValid && eligible[lockOwner]) begin
      winner = lockOwner;
    end else if (eligible[0] && eligible[1]) begin
      winner = other_req(lastGrant);
    end else if (eligible[1]) begin
      winner = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_arbiter.sv
// Two-requester arbiter for the single register-file access port.
// Each operation runs IDLE -> ISSUE -> CAPTURE and returns a one-cycle ack.
// Optional feature macro: REGFILE_ARB_LOCK_EN (adds reqLock and a lock counter).
module regfile_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned LOCK_MAX = LOCK_MAX_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] reqWrite,
  input  logic [ADDR_W-1:0]  reqAddr0,
  input  logic [ADDR_W-1:0]  reqAddr1,
  input  logic [DATA_W-1:0]  reqData0,
  input  logic [DATA_W-1:0]  reqData1,
`ifdef REGFILE_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0] reqLock,
`endif
  output logic [NUM_REQ-1:0] ack,
  output logic [DATA_W-1:0]  respData,
  output logic               busy,
  output logic               rfRegWrite,
  output logic [ADDR_W-1:0]  rfAddr,
  output logic [DATA_W-1:0]  rfWriteData,
  input  logic [DATA_W-1:0]  rfReadData
);

  localparam int unsigned CNT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

  arb_state_t state, stateNext;

  logic              lastGrant;
  logic              grantIdx;
  logic              latWrite;
  logic [ADDR_W-1:0] latAddr;
  logic [DATA_W-1:0] latData;
  logic [CNT_W-1:0]  lockCnt;

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] lockReq;
  logic               pickWinner;
  logic               pickValid;
  logic [CNT_W-1:0]   lockBase;
  logic [CNT_W-1:0]   lockCntNext;

`ifdef REGFILE_ARB_LOCK_EN
  assign lockReq = reqLock;
`else
  assign lockReq = '0;
`endif

  // The requester being acked still shows its old req this cycle; hide it.
  assign eligible = req & ~ack;

  // A non-zero count means the previous grant was locked and may be extended.
  rr_picker u_picker (
    .eligible  (eligible),
    .lastGrant (lastGrant),
    .lockValid (|lockCnt),
    .lockOwner (lastGrant),
    .winner    (pickWinner),
    .valid     (pickValid)
  );

  // Lock count for the grant about to be made: continues only for the same owner.
  always_comb begin
    lockBase    = (pickWinner == lastGrant) ? lockCnt : '0;
    lockCntNext = '0;
    if (lockReq[pickWinner] && (lockBase < CNT_LAST)) begin
      lockCntNext = lockBase + 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state: a fixed three-step walk once a grant is made.
  always_comb begin
    stateNext = IDLE;
    unique case (state)
      IDLE:    stateNext = pickValid ? ISSUE : IDLE;
      ISSUE:   stateNext = CAPTURE;
      CAPTURE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Grant latching, arbitration history, and the registered response.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lastGrant <= 1'b1;
      grantIdx  <= 1'b0;
      latWrite  <= 1'b0;
      latAddr   <= '0;
      latData   <= '0;
      lockCnt   <= '0;
      ack       <= '0;
      respData  <= '0;
    end else begin
      ack <= '0;
      unique case (state)
        IDLE: begin
          if (pickValid) begin
            grantIdx  <= pickWinner;
            lastGrant <= pickWinner;
            latWrite  <= reqWrite[pickWinner];
            latAddr   <= pickWinner ? reqAddr1 : reqAddr0;
            latData   <= pickWinner ? reqData1 : reqData0;
            lockCnt   <= lockCntNext;
          end
        end
        CAPTURE: begin
          ack[grantIdx] <= 1'b1;
          if (!latWrite) begin
            respData <= rfReadData;
          end
        end
        default: ;
      endcase
    end
  end

  // Register-file port is driven only during ISSUE; zero otherwise.
  always_comb begin
    busy        = (state != IDLE);
    rfRegWrite  = 1'b0;
    rfAddr      = '0;
    rfWriteData = '0;
    if (state == ISSUE) begin
      rfRegWrite  = latWrite;
      rfAddr      = latAddr;
      rfWriteData = latData;
    end
  end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Self-checking bench for regfile_arbiter with a behavioural register file.
module tb_regfile_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] req = 2'b00;
  logic [1:0] reqWrite = 2'b00;
  logic [2:0] reqAddr0 = 3'd0;
  logic [2:0] reqAddr1 = 3'd0;
  logic [7:0] reqData0 = 8'd0;
  logic [7:0] reqData1 = 8'd0;
`ifdef REGFILE_ARB_LOCK_EN
  logic [1:0] reqLock = 2'b00;
`endif
  logic [1:0] ack;
  logic [7:0] respData;
  logic       busy;
  logic       rfRegWrite;
  logic [2:0] rfAddr;
  logic [7:0] rfWriteData;
  logic [7:0] rfReadData = 8'h00;

  logic [7:0] rfMem [8] = '{default: 8'h00};

  // Reference state: register contents, last grant, last read result.
  logic [7:0] modelMem [8] = '{default: 8'h00};
  logic       modelLast = 1'b1;
  logic [7:0] modelResp = 8'h00;

  int total = 0;
  int bad = 0;

  regfile_arbiter #(.DATA_W(8), .ADDR_W(3), .LOCK_MAX(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .reqWrite    (reqWrite),
    .reqAddr0    (reqAddr0),
    .reqAddr1    (reqAddr1),
    .reqData0    (reqData0),
    .reqData1    (reqData1),
`ifdef REGFILE_ARB_LOCK_EN
    .reqLock     (reqLock),
`endif
    .ack         (ack),
    .respData    (respData),
    .busy        (busy),
    .rfRegWrite  (rfRegWrite),
    .rfAddr      (rfAddr),
    .rfWriteData (rfWriteData),
    .rfReadData  (rfReadData)
  );

  always #5 clock = ~clock;

  // Register file: samples address at the edge, data valid the next cycle.
  always @(posedge clock) begin
    if (rfRegWrite) rfMem[rfAddr] <= rfWriteData;
    rfReadData <= rfMem[rfAddr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Single-requester operation, no timing checks beyond completing.
  task automatic drive_op(input int r, input logic wr, input logic [2:0] a, input logic [7:0] d);
    logic seen;
    seen = 1'b0;
    reqWrite[r] = wr;
    if (r == 0) begin reqAddr0 = a; reqData0 = d; end
    else begin reqAddr1 = a; reqData1 = d; end
    req[r] = 1'b1;
    for (int k = 0; k < 10 && !seen; k++) begin
      tick();
      if (ack[r]) seen = 1'b1;
    end
    tick();
    req[r] = 1'b0;
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL op_ack r=%0d got=none want=ack", r);
    end
    modelLast = r[0];
    if (wr) modelMem[a] = d;
    else modelResp = modelMem[a];
  endtask

  task automatic test_reset();
    req = 2'b11; reqWrite = 2'b00; reqAddr0 = 3'd5; reqAddr1 = 3'd6;
    reset = 1'b1;
    tick(); tick(); tick();
    total += 6;
    if (ack !== 2'b00) begin bad++; $display("FAIL rst_ack got=%b want=00", ack); end
    if (respData !== 8'h00) begin bad++; $display("FAIL rst_resp got=%h want=00", respData); end
    if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    if (rfRegWrite !== 1'b0) begin bad++; $display("FAIL rst_we got=%b want=0", rfRegWrite); end
    if (rfAddr !== 3'd0) begin bad++; $display("FAIL rst_addr got=%0d want=0", rfAddr); end
    if (rfWriteData !== 8'h00) begin bad++; $display("FAIL rst_wd got=%h want=00", rfWriteData); end
    reset = 1'b0;
    tick();
    total += 2;
    if (busy !== 1'b1) begin bad++; $display("FAIL first_busy got=%b want=1", busy); end
    if (rfAddr !== 3'd5) begin bad++; $display("FAIL first_addr got=%0d want=5", rfAddr); end
    tick(); tick();
    total++;
    if (ack !== 2'b01) begin bad++; $display("FAIL first_ack got=%b want=01", ack); end
    tick();
    req[0] = 1'b0;
    tick(); tick();
    total++;
    if (ack !== 2'b10) begin bad++; $display("FAIL second_ack got=%b want=10", ack); end
    tick();
    req[1] = 1'b0;
    modelLast = 1'b1;
    modelResp = modelMem[6];
  endtask

  task automatic test_write_read();
    reqWrite = 2'b01; reqAddr0 = 3'd3; reqData0 = 8'hA5; req = 2'b01;
    tick();
    total += 3;
    if (rfRegWrite !== 1'b1) begin bad++; $display("FAIL wr_we_c1 got=%b want=1", rfRegWrite); end
    if (rfAddr !== 3'd3) begin bad++; $display("FAIL wr_addr got=%0d want=3", rfAddr); end
    if (rfWriteData !== 8'hA5) begin bad++; $display("FAIL wr_data got=%h want=a5", rfWriteData); end
    reqAddr0 = 3'd7; reqData0 = 8'h5A;
    tick();
    total++;
    if (rfRegWrite !== 1'b0) begin bad++; $display("FAIL wr_we_c2 got=%b want=0", rfRegWrite); end
    tick();
    total += 3;
    if (ack !== 2'b01) begin bad++; $display("FAIL wr_ack got=%b want=01", ack); end
    if (rfRegWrite !== 1'b0) begin bad++; $display("FAIL wr_we_c3 got=%b want=0", rfRegWrite); end
    if (respData !== modelResp) begin bad++; $display("FAIL wr_resp_keep got=%h want=%h", respData, modelResp); end
    modelMem[3] = 8'hA5;
    modelLast = 1'b0;
    // req was still high at the ack edge: it must not issue a second time
    tick();
    total += 2;
    if (busy !== 1'b0) begin bad++; $display("FAIL hold_busy got=%b want=0", busy); end
    if (ack !== 2'b00) begin bad++; $display("FAIL hold_ack got=%b want=00", ack); end
    req = 2'b00;
    tick();
    reqWrite = 2'b00; reqAddr0 = 3'd3; req = 2'b01;
    tick();
    total += 2;
    if (rfRegWrite !== 1'b0) begin bad++; $display("FAIL rd_we got=%b want=0", rfRegWrite); end
    if (rfAddr !== 3'd3) begin bad++; $display("FAIL rd_addr got=%0d want=3", rfAddr); end
    tick(); tick();
    total += 2;
    if (ack !== 2'b01) begin bad++; $display("FAIL rd_ack got=%b want=01", ack); end
    if (respData !== 8'hA5) begin bad++; $display("FAIL rd_resp got=%h want=a5", respData); end
    tick();
    req = 2'b00;
    modelResp = 8'hA5;
  endtask

  task automatic test_alternate();
    drive_op(0, 1'b1, 3'd1, 8'h11);
    drive_op(1, 1'b1, 3'd2, 8'h22);
    reqWrite = 2'b00; reqAddr0 = 3'd1; reqAddr1 = 3'd2; req = 2'b11;
    for (int cyc = 1; cyc <= 13; cyc++) begin
      logic [1:0] eAck;
      tick();
      eAck = 2'b00;
      if (cyc % 3 == 0 && cyc <= 12) eAck = ((cyc / 3) % 2 == 1) ? 2'b01 : 2'b10;
      total++;
      if (ack !== eAck) begin bad++; $display("FAIL alt_ack cyc=%0d got=%b want=%b", cyc, ack, eAck); end
      if (eAck != 2'b00) begin
        total++;
        if (respData !== (eAck[0] ? 8'h11 : 8'h22)) begin
          bad++; $display("FAIL alt_resp cyc=%0d got=%h want=%h", cyc, respData, eAck[0] ? 8'h11 : 8'h22);
        end
      end
      if (cyc == 12) req = 2'b00;
      if (cyc == 13) begin
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL alt_idle got=%b want=0", busy); end
      end
    end
    modelLast = 1'b1;
    modelResp = 8'h22;
  endtask

  task automatic test_reset_capture();
    reqWrite = 2'b00; reqAddr0 = 3'd3; req = 2'b01;
    tick(); tick();
    #2 reset = 1'b1;
    #1;
    total += 3;
    if (ack !== 2'b00) begin bad++; $display("FAIL rc_ack got=%b want=00", ack); end
    if (respData !== 8'h00) begin bad++; $display("FAIL rc_resp got=%h want=00", respData); end
    if (busy !== 1'b0) begin bad++; $display("FAIL rc_busy got=%b want=0", busy); end
    req = 2'b00;
    tick();
    total += 2;
    if (ack !== 2'b00) begin bad++; $display("FAIL rc_ack2 got=%b want=00", ack); end
    if (respData !== 8'h00) begin bad++; $display("FAIL rc_resp2 got=%h want=00", respData); end
    reset = 1'b0;
    tick();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL rc_idle got=%b want=0", busy); end
    modelLast = 1'b1;
    modelResp = 8'h00;
  endtask

`ifdef REGFILE_ARB_LOCK_EN
  task automatic test_lock();
    logic [1:0] want;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    modelLast = 1'b1;
    modelResp = 8'h00;
    reqWrite = 2'b00; reqAddr0 = 3'd1; reqAddr1 = 3'd2; reqLock = 2'b01;
    for (int rd = 0; rd < 5; rd++) begin
      want = (rd < 4) ? 2'b01 : 2'b10;
      req = 2'b11;
      tick();
      req = want;
      tick(); tick();
      total++;
      if (ack !== want) begin bad++; $display("FAIL lock_grant round=%0d got=%b want=%b", rd, ack, want); end
      tick();
      req = 2'b00;
    end
    reqLock = 2'b00;
    modelLast = 1'b1;
    modelResp = modelMem[2];
  endtask
`endif

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      logic [1:0] p;
      logic [1:0] w;
      logic [2:0] a [2];
      logic [7:0] d [2];
      logic       two;
      logic [1:0] dropNext;
      int         first;
      int         second;
      p = 2'($urandom_range(1, 3));
      w = 2'($urandom);
      for (int r = 0; r < 2; r++) begin
        a[r] = 3'($urandom);
        d[r] = 8'($urandom);
      end
      two = (p == 2'b11);
      if (two) first = modelLast ? 0 : 1;
      else first = p[1] ? 1 : 0;
      second = 1 - first;
      reqWrite = w; reqAddr0 = a[0]; reqAddr1 = a[1];
      reqData0 = d[0]; reqData1 = d[1]; req = p;
      dropNext = 2'b00;
      for (int cyc = 1; cyc <= 7; cyc++) begin
        logic [1:0] eAck;
        logic       eBusy;
        logic       issue;
        logic       eWe;
        logic [2:0] eAddr;
        logic [7:0] eWd;
        int         cur;
        tick();
        req = req & ~dropNext;
        dropNext = 2'b00;
        cur = (cyc <= 3) ? first : second;
        issue = (cyc == 1) || (two && cyc == 4);
        eBusy = (cyc == 1 || cyc == 2) || (two && (cyc == 4 || cyc == 5));
        eWe = issue && w[cur];
        eAddr = issue ? a[cur] : 3'd0;
        eWd = issue ? d[cur] : 8'd0;
        eAck = 2'b00;
        if (cyc == 3 || (two && cyc == 6)) eAck[cur] = 1'b1;
        if (issue) begin
          modelLast = cur[0];
          if (w[cur]) modelMem[a[cur]] = d[cur];
          else modelResp = modelMem[a[cur]];
        end
        total += 5;
        if (ack !== eAck) begin bad++; $display("FAIL rnd_ack it=%0d cyc=%0d got=%b want=%b", it, cyc, ack, eAck); end
        if (busy !== eBusy) begin bad++; $display("FAIL rnd_busy it=%0d cyc=%0d got=%b want=%b", it, cyc, busy, eBusy); end
        if (rfRegWrite !== eWe) begin bad++; $display("FAIL rnd_we it=%0d cyc=%0d got=%b want=%b", it, cyc, rfRegWrite, eWe); end
        if (rfAddr !== eAddr) begin bad++; $display("FAIL rnd_addr it=%0d cyc=%0d got=%0d want=%0d", it, cyc, rfAddr, eAddr); end
        if (rfWriteData !== eWd) begin bad++; $display("FAIL rnd_wd it=%0d cyc=%0d got=%h want=%h", it, cyc, rfWriteData, eWd); end
        if (eAck != 2'b00) begin
          total++;
          if (respData !== modelResp) begin
            bad++; $display("FAIL rnd_resp it=%0d cyc=%0d got=%h want=%h", it, cyc, respData, modelResp);
          end
          dropNext = eAck;
        end
        // granted requester's inputs are no longer looked at
        if (issue) begin
          if (cur == 0) begin reqAddr0 = 3'($urandom); reqData0 = 8'($urandom); end
          else begin reqAddr1 = 3'($urandom); reqData1 = 8'($urandom); end
          reqWrite[cur] = ~reqWrite[cur];
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_alternate();
    test_reset_capture();
`ifdef REGFILE_ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
